// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI4 encodings and fetch FSM state type
package axi_pkg;

  // Transfer size and burst encodings
  localparam logic [2:0] AXI_SIZE_4B   = 3'b010;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // Read/write response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Default master IDs on the interconnect
  localparam logic [3:0] AXI_ID_IM = 4'd0;
  localparam logic [3:0] AXI_ID_DM = 4'd1;

  typedef enum logic [1:0] {IDLE, AR, R, DONE} fetch_state_t;

endpackage

// File: rtl/im_fetch_master.sv
// rtl/im_fetch_master.sv - single-beat AXI4 instruction fetch engine for the IF stage
module im_fetch_master
  import axi_pkg::*;
#(
  parameter logic [3:0]  MASTER_ID = AXI_ID_IM,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        im_access,
  input  logic [31:0] im_addr,
  output logic [31:0] im_inst,
  output logic        im_stall,
  output logic        fetch_err,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY
);

  fetch_state_t state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  inst_q, inst_d;
  logic         err_q, err_d;
  logic         beat_done;

  // Only the last beat carrying our ID ends the fetch; anything else is drained
  assign beat_done = RVALID & RLAST & (RID == MASTER_ID);

  // State, latched address, instruction and error flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      inst_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and handshake outputs; ARVALID/RREADY come from state only
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    err_d   = 1'b0;
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (im_access) begin
          addr_d  = {im_addr[31:2], 2'b00};
          state_d = AR;
        end
      end
      AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = R;
      end
      R: begin
        RREADY = 1'b1;
        if (beat_done) begin
          if (RRESP == AXI_RESP_OKAY) begin
            inst_d = RDATA;
          end else begin
            inst_d = NOP_INST;
            err_d  = 1'b1;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign im_stall  = im_access & (state_q != DONE);
  assign im_inst   = inst_q;
  assign fetch_err = err_q;
  assign ARID      = MASTER_ID;
  assign ARADDR    = addr_q;
  assign ARLEN     = 4'd0;
  assign ARSIZE    = AXI_SIZE_4B;
  assign ARBURST   = AXI_BURST_INCR;

endmodule
